shift_add_mul: RTL and testbench
================================

SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, legal values 8..64, even.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: multiplicand.
REQ-006 SHALL have port b, input, WIDTH bits: multiplier.
REQ-007 SHALL have port a_signed, input, 1 bit: 1 means a is two's-complement, 0 means unsigned.
REQ-008 SHALL have port b_signed, input, 1 bit: 1 means b is two's-complement, 0 means unsigned.
REQ-009 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the product registers update.
REQ-011 SHALL have port product_lo, output, WIDTH bits: low half of the 2*WIDTH product; maps to MUL.
REQ-012 SHALL have port product_hi, output, WIDTH bits: high half of the product; maps to MULH, MULHSU and MULHU.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and FIX; reset state is IDLE.
REQ-014 In IDLE with start=1 at edge k, SHALL capture |a|, |b| (magnitude only where the operand is signed and negative) and neg = sign(a) XOR sign(b), clear the 2*WIDTH accumulator and the step counter, and go to RUN.
REQ-015 Magnitude of the most-negative signed value (e.g. -2^(WIDTH-1)) SHALL be 2^(WIDTH-1) as an unsigned WIDTH-bit value, with no overflow.
REQ-016 In RUN, each edge SHALL add the shifted multiplicand to the accumulator when the current multiplier LSB is 1, then shift the multiplier right and the multiplicand left, and increment the counter.
REQ-017 Accumulator additions SHALL be 2*WIDTH bits wide, carry-in 0, with the carry-out discarded.
REQ-018 RUN SHALL last exactly WIDTH edges (k+1..k+WIDTH), then go to FIX.
REQ-019 In FIX (edge k+WIDTH+1), SHALL write the accumulator, two's-complement negated when neg=1, to {product_hi, product_lo}, assert done for one cycle, and go to IDLE.
REQ-020 Latency from the start edge to done high SHALL be WIDTH+1 cycles; busy SHALL be high in cycles k+1..k+WIDTH+1.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in progress or on the outputs.
REQ-022 start in the cycle done is high SHALL be accepted, because the FSM is in IDLE; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-023 product_hi and product_lo SHALL hold their last value until the next FIX; a, b and the sign inputs SHALL be don't-care after the capture edge.
REQ-024 A zero operand SHALL produce a zero result with neg cleared, so there is never a negative zero.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, product_lo=0, product_hi=0, accumulator and counter 0.
REQ-026 Reset asserted mid-RUN or in FIX SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Configuration
REQ-027 The macro SHALL be MUL_EARLY_EXIT_EN.
REQ-028 With MUL_EARLY_EXIT_EN defined, RUN SHALL go to FIX on the edge after the remaining shifted multiplier becomes zero; latency becomes (index of the highest set bit of |b|)+2 cycles, and 2 cycles when |b|=0.
REQ-029 Without MUL_EARLY_EXIT_EN, latency SHALL be fixed at WIDTH+1 cycles for all operands (REQ-020).

Verification (WIDTH=32)
REQ-030 a=7, b=6, both unsigned, start -> done exactly 33 cycles later, hi=0x00000000, lo=0x0000002A.
REQ-031 a=0xFFFFFFFF, b=0xFFFFFFFF, both signed -> hi=0x00000000, lo=0x00000001; both unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 a=0x80000000, b=0x80000000, both signed -> hi=0x40000000, lo=0x00000000; a signed, b unsigned (MULHSU) with a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 start pulsed again at cycle 5 of a RUN -> ignored, first result correct, busy never drops early; start in the done cycle -> second result correct at done+33.
REQ-034 rst_n low at RUN cycle 10 -> busy=0, outputs 0, no done pulse; next start with a=3, b=5 -> lo=15.
REQ-035 With MUL_EARLY_EXIT_EN: b=1 -> done 2 cycles after start; b=0 -> 2 cycles, result 0; b=0x80000000 unsigned -> 33 cycles.

Source files
------------

// File: rtl/shift_add_mul.sv
// Iterative shift-and-add multiplier with per-operand signedness and a 2*WIDTH product.
// Optional macro MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_signed,
    input  logic             b_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 done_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     hi_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     mplier_d;
    logic                 last_step;

    // Negating the most-negative value wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign a_neg = a_signed & a[WIDTH-1];
    assign b_neg = b_signed & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_d = mplier_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_d == '0);
`else
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        // A zero operand forces a positive result so -0 never appears.
                        neg_q    <= (a_neg ^ b_neg) && (a != '0) && (b != '0);
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    {hi_q, lo_q} <= neg_q ? -acc_q : acc_q;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign product_lo = lo_q;
    assign product_hi = hi_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: randomized and directed multiplies against a plain-arithmetic model.
// Expected latency follows MUL_EARLY_EXIT_EN when the bench is built with that macro.
module tb_shift_add_mul;

    localparam int W = 32;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         start    = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic         a_signed = 1'b0;
    logic         b_signed = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] product_lo;
    logic [W-1:0] product_hi;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           start_cyc;
        int           done_cyc;
    } exp_t;

    exp_t q[$];

    shift_add_mul #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .a_signed   (a_signed),
        .b_signed   (b_signed),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic sx, input logic sy);
        logic [2*W-1:0] ex;
        logic [2*W-1:0] ey;
        ex = sx ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = sy ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] y, input logic sy);
        logic [W-1:0] m;
        int top;
        m   = (sy && y[W-1]) ? -y : y;
        top = 0;
        for (int i = 0; i < W; i++) if (m[i]) top = i;
        return EARLY ? top + 2 : W + 1;
    endfunction

    // Issue one multiply as soon as the DUT is idle; expectations go to the scoreboard.
    task automatic go(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic sai, input logic sbi,
                      input bit use_exp, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n;
        exp_t e;
        logic [2*W-1:0] p;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 1'b0);
        a        = ai;
        b        = bi;
        a_signed = sai;
        b_signed = sbi;
        start    = 1'b1;
        p        = ref_prod(ai, bi, sai, sbi);
        e.hi        = use_exp ? ehi : p[2*W-1:W];
        e.lo        = use_exp ? elo : p[W-1:0];
        e.start_cyc = cyc + 1;
        e.done_cyc  = cyc + 1 + ref_lat(bi, sbi);
        q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        a_signed = 1'($urandom);
        b_signed = 1'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && cyc >= q[0].start_cyc && cyc < q[0].done_cyc)
                chk("busy_held", busy, 1'b1);
            if (done) begin : pop
                exp_t e;
                if (q.size() == 0) begin
                    chk("spurious_done", done, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("product_hi", product_hi, e.hi);
                    chk("product_lo", product_lo, e.lo);
                    chk("latency_cycle", cyc, e.done_cyc);
                    chk("busy_at_done", busy, 1'b0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_lo", product_lo, '0);
        chk("reset_hi", product_hi, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed values; consecutive calls also exercise start in the done cycle.
        go(32'd7, 32'd6, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_002A);
        go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001);
        go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        go(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h4000_0000, 32'h0000_0000);
        go(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        go(32'h1234_5678, 32'd1, 1'b0, 1'b0, 1'b0, '0, '0);
        go(32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000);
        go(32'd9, 32'h8000_0000, 1'b0, 1'b0, 1'b0, '0, '0);
        go(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000);

        // Start pulsed mid-operation must be ignored.
        go(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        a = 32'hAAAA_AAAA;
        b = 32'h5555_5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset in the middle of RUN aborts with no done pulse.
        go(32'h0001_0001, 32'hFFFF_0003, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (9) @(negedge clk);
        q.delete();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_lo", product_lo, '0);
        chk("abort_hi", product_hi, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        go(32'd3, 32'd5, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_000F);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = '0;
                1: rb = '0;
                2: ra = 32'h8000_0000;
                3: rb = 32'h8000_0000;
                4: rb = W'($urandom_range(0, 255));
                default: ;
            endcase
            go(ra, rb, 1'($urandom), 1'($urandom), 1'b0, '0, '0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        n = 0;
        while (q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
